mem_access_stage: RTL

Memory-access stage of the pipelined RV32 core, directly downstream of the execution stage. It takes the registered ALU result, store data and destination register from execution, runs a request/acknowledge transaction on the data-memory port for loads and stores, and aligns sub-word data. It presents a single registered writeback bundle to the register file and stalls upstream while a memory transaction is outstanding.

---
 rtl/core_pkg.sv | 15 +
 rtl/mem_align.sv | 79 +++++++
 rtl/mem_access_stage.sv | 159 +++++++++++++++
 3 files changed

// File: rtl/core_pkg.sv
// rtl/core_pkg.sv - shared RV32 core constants and memory-stage FSM encoding
package core_pkg;

    localparam logic [2:0] F3_B  = 3'b000;
    localparam logic [2:0] F3_H  = 3'b001;
    localparam logic [2:0] F3_W  = 3'b010;
    localparam logic [2:0] F3_BU = 3'b100;
    localparam logic [2:0] F3_HU = 3'b101;

    typedef enum logic {
        MEM_IDLE = 1'b0,
        MEM_REQ  = 1'b1
    } mem_state_e;

endpackage

// File: rtl/mem_align.sv
// rtl/mem_align.sv - store lane generation, load lane extraction, access legality
module mem_align
    import core_pkg::*;
(
    input  logic [1:0]  st_offset_i,
    input  logic [2:0]  st_funct3_i,
    input  logic        st_read_i,
    input  logic        st_write_i,
    input  logic [31:0] st_data_i,
    output logic [3:0]  st_be_o,
    output logic [31:0] st_wdata_o,
    output logic        bad_o,
    input  logic [1:0]  ld_offset_i,
    input  logic [2:0]  ld_funct3_i,
    input  logic [31:0] ld_rdata_i,
    output logic [31:0] ld_data_o
);

    logic        illegal;
    logic        unaligned;
    logic [7:0]  ld_byte;
    logic [15:0] ld_half;

    always_comb begin
        illegal    = 1'b0;
        unaligned  = 1'b0;
        st_be_o    = 4'b0000;
        st_wdata_o = 32'h0;
        case (st_funct3_i)
            F3_B, F3_BU: unaligned = 1'b0;
            F3_H, F3_HU: unaligned = st_offset_i[0];
            F3_W:        unaligned = |st_offset_i;
            default:     illegal   = 1'b1;
        endcase
        // Stores have no unsigned variants.
        if (st_write_i && st_funct3_i[2]) begin
            illegal = 1'b1;
        end
        bad_o = (st_read_i | st_write_i) & (illegal | unaligned);
        if (st_write_i) begin
            case (st_funct3_i)
                F3_B: begin
                    st_be_o    = 4'b0001 << st_offset_i;
                    st_wdata_o = {4{st_data_i[7:0]}};
                end
                F3_H: begin
                    st_be_o    = 4'b0011 << {st_offset_i[1], 1'b0};
                    st_wdata_o = {2{st_data_i[15:0]}};
                end
                F3_W: begin
                    st_be_o    = 4'b1111;
                    st_wdata_o = st_data_i;
                end
                default: begin
                    st_be_o    = 4'b0000;
                    st_wdata_o = 32'h0;
                end
            endcase
        end
    end

    always_comb begin
        case (ld_offset_i)
            2'd0:    ld_byte = ld_rdata_i[7:0];
            2'd1:    ld_byte = ld_rdata_i[15:8];
            2'd2:    ld_byte = ld_rdata_i[23:16];
            default: ld_byte = ld_rdata_i[31:24];
        endcase
        ld_half = ld_offset_i[1] ? ld_rdata_i[31:16] : ld_rdata_i[15:0];
        case (ld_funct3_i)
            F3_B:    ld_data_o = {{24{ld_byte[7]}}, ld_byte};
            F3_H:    ld_data_o = {{16{ld_half[15]}}, ld_half};
            F3_BU:   ld_data_o = {24'h0, ld_byte};
            F3_HU:   ld_data_o = {16'h0, ld_half};
            default: ld_data_o = ld_rdata_i;
        endcase
    end

endmodule

// File: rtl/mem_access_stage.sv
// rtl/mem_access_stage.sv - RV32 memory-access stage with req/ack data port and writeback register
module mem_access_stage
    import core_pkg::*;
(
    input  logic        clk,
    input  logic        rstn,
    input  logic        ex_valid,
    input  logic [31:0] ALU_result,
    input  logic [31:0] Rdata2,
    input  logic        mem_read,
    input  logic        mem_write,
    input  logic [2:0]  funct3,
    input  logic [4:0]  rd,
    input  logic        reg_write,
    output logic        stall_out,
    output logic        dmem_req,
    output logic        dmem_we,
    output logic [31:0] dmem_addr,
    output logic [31:0] dmem_wdata,
    output logic [3:0]  dmem_be,
    input  logic [31:0] dmem_rdata,
    input  logic        dmem_ack,
    output logic        wb_valid,
    output logic        wb_we,
    output logic [4:0]  wb_rd,
    output logic [31:0] wb_data,
    output logic        misaligned
);

    mem_state_e  state_q, state_d;

    logic        req_q, we_q;
    logic [31:0] addr_q, wdata_q;
    logic [3:0]  be_q;
    logic [1:0]  ld_off_q;
    logic [2:0]  ld_f3_q;
    logic        is_load_q;
    logic [4:0]  rd_q;
    logic        reg_write_q;

    logic        wb_valid_q, wb_we_q, misaligned_q;
    logic [4:0]  wb_rd_q;
    logic [31:0] wb_data_q;

    logic        accept;
    logic        mem_op;
    logic        bad;
    logic        legal_mem;
    logic [3:0]  st_be;
    logic [31:0] st_wdata;
    logic [31:0] ld_data;

    mem_align u_align (
        .st_offset_i (ALU_result[1:0]),
        .st_funct3_i (funct3),
        .st_read_i   (mem_read),
        .st_write_i  (mem_write),
        .st_data_i   (Rdata2),
        .st_be_o     (st_be),
        .st_wdata_o  (st_wdata),
        .bad_o       (bad),
        .ld_offset_i (ld_off_q),
        .ld_funct3_i (ld_f3_q),
        .ld_rdata_i  (dmem_rdata),
        .ld_data_o   (ld_data)
    );

    assign accept    = (state_q == MEM_IDLE) && ex_valid;
    assign mem_op    = mem_read | mem_write;
    assign legal_mem = mem_op & ~bad;
    assign stall_out = (state_q == MEM_REQ) | (accept & legal_mem);

    always_comb begin
        state_d = state_q;
        case (state_q)
            MEM_IDLE: if (ex_valid && legal_mem) state_d = MEM_REQ;
            MEM_REQ:  if (dmem_ack)              state_d = MEM_IDLE;
            default:                             state_d = MEM_IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            state_q <= MEM_IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            req_q        <= 1'b0;
            we_q         <= 1'b0;
            addr_q       <= 32'h0;
            wdata_q      <= 32'h0;
            be_q         <= 4'b0000;
            ld_off_q     <= 2'd0;
            ld_f3_q      <= 3'd0;
            is_load_q    <= 1'b0;
            rd_q         <= 5'd0;
            reg_write_q  <= 1'b0;
            wb_valid_q   <= 1'b0;
            wb_we_q      <= 1'b0;
            wb_rd_q      <= 5'd0;
            wb_data_q    <= 32'h0;
            misaligned_q <= 1'b0;
        end else begin
            wb_valid_q   <= 1'b0;
            misaligned_q <= 1'b0;
            if (accept) begin
                if (!mem_op) begin
                    wb_valid_q <= 1'b1;
                    wb_we_q    <= reg_write && (rd != 5'd0);
                    wb_rd_q    <= rd;
                    wb_data_q  <= ALU_result;
                end else if (bad) begin
                    // Faulting op retires without a write; wb_data carries its address.
                    misaligned_q <= 1'b1;
                    wb_valid_q   <= 1'b1;
                    wb_we_q      <= 1'b0;
                    wb_rd_q      <= rd;
                    wb_data_q    <= ALU_result;
                end else begin
                    req_q       <= 1'b1;
                    we_q        <= mem_write;
                    addr_q      <= {ALU_result[31:2], 2'b00};
                    be_q        <= st_be;
                    wdata_q     <= st_wdata;
                    ld_off_q    <= ALU_result[1:0];
                    ld_f3_q     <= funct3;
                    is_load_q   <= ~mem_write;
                    rd_q        <= rd;
                    reg_write_q <= reg_write;
                end
            end else if ((state_q == MEM_REQ) && dmem_ack) begin
                req_q      <= 1'b0;
                we_q       <= 1'b0;
                wb_valid_q <= 1'b1;
                wb_rd_q    <= rd_q;
                wb_we_q    <= is_load_q && reg_write_q && (rd_q != 5'd0);
                if (is_load_q) begin
                    wb_data_q <= ld_data;
                end
            end
        end
    end

    assign dmem_req   = req_q;
    assign dmem_we    = we_q;
    assign dmem_addr  = addr_q;
    assign dmem_wdata = wdata_q;
    assign dmem_be    = be_q;
    assign wb_valid   = wb_valid_q;
    assign wb_we      = wb_we_q;
    assign wb_rd      = wb_rd_q;
    assign wb_data    = wb_data_q;
    assign misaligned = misaligned_q;

endmodule
